// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC, and holds the IF/ID register.
// Optional FETCH_PERF_CNT_EN macro adds fetch_count / stall_count performance counters.
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_f,
    input  logic                     stall_d,
    input  logic                     flush_d,
    input  logic [1:0]               pc_src,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    input  logic [ADDRESS_WIDTH-1:0] jump_target,
    output logic [ADDRESS_WIDTH-1:0] instr_addr,
    input  logic [INSTR_WIDTH-1:0]   instr_in,
    output logic [INSTR_WIDTH-1:0]   instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]              fetch_count,
    output logic [31:0]              stall_count,
`endif
    output logic                     valid_d
);

    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(4);

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d_nxt;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_q, pc_plus4_d_nxt;
    logic                     valid_q, valid_d_nxt;
    logic                     load_real;

    // Fetch: next-PC selection; targets are masked so the PC stays word aligned.
    always_comb begin
        pc_plus4 = pc_q + PC_STEP;
        case (pc_src)
            2'd1:    pc_next = branch_target & ALIGN_MASK;
            2'd2:    pc_next = jump_target & ALIGN_MASK;
            default: pc_next = pc_plus4;
        endcase
        pc_d = stall_f ? pc_q : pc_next;
    end

    always_comb begin
        instr_d_nxt    = instr_q;
        pc_plus4_d_nxt = pc_plus4_q;
        valid_d_nxt    = valid_q;
        load_real      = 1'b0;
        if (flush_d) begin
            instr_d_nxt    = '0;
            pc_plus4_d_nxt = '0;
            valid_d_nxt    = 1'b0;
        end else if (!stall_d) begin
            instr_d_nxt    = instr_in;
            pc_plus4_d_nxt = pc_plus4;
            valid_d_nxt    = 1'b1;
            load_real      = 1'b1;
        end
    end

    // IF/ID boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d_nxt;
            pc_plus4_q <= pc_plus4_d_nxt;
            valid_q    <= valid_d_nxt;
        end
    end

    assign instr_addr = pc_q;
    assign instr_d    = instr_q;
    assign pc_plus4_d = pc_plus4_q;
    assign valid_d    = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = load_real ? fetch_count_q + 32'd1 : fetch_count_q;
        stall_count_d = stall_f   ? stall_count_q + 32'd1 : stall_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    logic unused_load_real;
    assign unused_load_real = load_real;
`endif

endmodule
